// File: rtl/bar_pkg.sv
// Shared parameters and types for the spectrum bar-height scheduler.
package bar_pkg;
    localparam int N_BARS       = 20;
    localparam int BINS_PER_BAR = 4;
    localparam int MAG_W        = 16;
    localparam int SHIFT        = 9;
    localparam int MAX_HEIGHT   = 48;
    localparam int DECAY        = 1;
    localparam int SETTLE_LEN   = 4;
    localparam int PULSE_LEN    = 8;
    localparam int PEAK_HOLD    = 16;
    localparam int BAR_W        = $clog2(N_BARS + 1);
    localparam int BIN_W        = $clog2(BINS_PER_BAR);
    localparam int TMR_W        = 3;

    typedef logic [5:0]       height_t;
    typedef height_t          bar_heights_t [N_BARS-1:0];
    typedef logic [MAG_W-1:0] mag_t;
    typedef logic [3:0]       hold_t;
    typedef enum logic [1:0] {IDLE, UPDATE, SETTLE, PULSE} sched_state_t;

    function automatic mag_t mag_max(input mag_t a, input mag_t b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/bar_height_scheduler_if.sv
// Magnitude stream handshake between the FFT magnitude source and the scheduler.
interface bar_height_scheduler_if;
    import bar_pkg::*;

    logic MAG_VALID;
    logic MAG_READY;
    mag_t MAG;
    logic MAG_LAST;

    modport master (output MAG_VALID, MAG, MAG_LAST, input MAG_READY);
    modport slave  (input MAG_VALID, MAG, MAG_LAST, output MAG_READY);
endinterface

// File: rtl/bar_decay_unit.sv
// Next height (instant attack, linear decay) and, with PEAK_HOLD_EN, peak marker for one bar.
module bar_decay_unit
    import bar_pkg::*;
(
    input  mag_t    snap_mag,
    input  logic    snap_valid,
    input  height_t cur_height,
`ifdef PEAK_HOLD_EN
    input  height_t cur_peak,
    input  hold_t   cur_hold,
    output height_t new_peak,
    output hold_t   new_hold,
`endif
    output height_t new_height
);
    logic [6:0] shifted;
    logic [6:0] target;
    logic [6:0] cur_ext;
    logic [6:0] next_ext;

    always_comb begin
        shifted = 7'(snap_mag >> SHIFT);
        if (!snap_valid)
            target = '0;
        else if (shifted > 7'(MAX_HEIGHT))
            target = 7'(MAX_HEIGHT);
        else
            target = shifted;
        cur_ext = {1'b0, cur_height};
        if (target >= cur_ext)
            next_ext = target;
        else if (cur_ext > 7'(DECAY))
            next_ext = cur_ext - 7'(DECAY);
        else
            next_ext = '0;
    end

    assign new_height = height_t'(next_ext);

`ifdef PEAK_HOLD_EN
    // A new or equal peak re-arms the hold; after it expires the marker sinks toward the bar.
    always_comb begin
        if (new_height >= cur_peak) begin
            new_peak = new_height;
            new_hold = hold_t'(PEAK_HOLD - 1);
        end else if (cur_hold != '0) begin
            new_peak = cur_peak;
            new_hold = cur_hold - 4'd1;
        end else begin
            new_hold = '0;
            new_peak = (height_t'(cur_peak - 6'd1) > new_height) ? height_t'(cur_peak - 6'd1) : new_height;
        end
    end
`endif
endmodule

// File: rtl/bar_height_scheduler.sv
// Max-reduces FFT bins into 20 bar heights, applies per-frame decay and strobes the renderer.
// Optional macro PEAK_HOLD_EN adds peak markers with a per-bar hold timer.
//
// state  | meaning
// IDLE   | accumulating, waiting for FRAME_TICK (or a pending tick)
// UPDATE | one bar per cycle rewritten from the snapshot, MAG_READY low
// SETTLE | heights stable, waiting before the capture strobe
// PULSE  | control_bit high for the renderer to capture heights
module bar_height_scheduler
    import bar_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET_N,
    bar_height_scheduler_if.slave mag_bus,
    input  logic                  FRAME_TICK,
    output bar_heights_t          height,
    output logic                  control_bit,
    output bar_heights_t          peak
);
    sched_state_t     state;
    sched_state_t     state_n;
    logic             pending;
    logic             ready;
    logic             upd_en;
    logic             pulse_n;
    logic [BAR_W-1:0] upd_idx;
    logic [TMR_W-1:0] timer;

    mag_t             acc  [N_BARS-1:0];
    mag_t             snap [N_BARS-1:0];
    logic             snap_valid;
    logic [BIN_W-1:0] bin_cnt;
    logic [BAR_W-1:0] bar_cnt;
    logic             accept;
    logic             in_range;
    mag_t             beat_max;
    height_t          dec_height;

`ifdef PEAK_HOLD_EN
    hold_t            hold [N_BARS-1:0];
    height_t          dec_peak;
    hold_t            dec_hold;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            pending     <= 1'b0;
            control_bit <= 1'b0;
        end else begin
            state       <= state_n;
            control_bit <= pulse_n;
            // Only one tick is remembered while busy; IDLE consumes it.
            if (state == IDLE)
                pending <= 1'b0;
            else if (FRAME_TICK)
                pending <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (FRAME_TICK || pending) state_n = UPDATE;
            UPDATE:  if (upd_idx == BAR_W'(N_BARS - 1)) state_n = SETTLE;
            SETTLE:  if (timer == '0) state_n = PULSE;
            PULSE:   if (timer == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ready   = (state != UPDATE);
        upd_en  = (state == UPDATE);
        pulse_n = (state_n == PULSE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            upd_idx <= '0;
            timer   <= '0;
        end else begin
            upd_idx <= (upd_en && state_n == UPDATE) ? upd_idx + 1'b1 : '0;
            if (state_n != state) begin
                case (state_n)
                    SETTLE:  timer <= TMR_W'(SETTLE_LEN - 1);
                    PULSE:   timer <= TMR_W'(PULSE_LEN - 1);
                    default: timer <= '0;
                endcase
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end

    assign mag_bus.MAG_READY = ready;
    assign accept   = mag_bus.MAG_VALID && ready;
    assign in_range = (bar_cnt < BAR_W'(N_BARS));
    assign beat_max = in_range ? mag_max(acc[bar_cnt], mag_bus.MAG) : mag_bus.MAG;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_BARS; i++) begin
                acc[i]  <= '0;
                snap[i] <= '0;
            end
            snap_valid <= 1'b0;
            bin_cnt    <= '0;
            bar_cnt    <= '0;
        end else if (accept) begin
            if (mag_bus.MAG_LAST) begin
                for (int i = 0; i < N_BARS; i++) begin
                    snap[i] <= (in_range && bar_cnt == BAR_W'(i)) ? beat_max : acc[i];
                    acc[i]  <= '0;
                end
                snap_valid <= 1'b1;
                bin_cnt    <= '0;
                bar_cnt    <= '0;
            end else begin
                if (in_range)
                    acc[bar_cnt] <= beat_max;
                // bar_cnt parks at N_BARS so surplus bins fall out of range.
                if (bin_cnt == BIN_W'(BINS_PER_BAR - 1)) begin
                    bin_cnt <= '0;
                    if (in_range)
                        bar_cnt <= bar_cnt + 1'b1;
                end else begin
                    bin_cnt <= bin_cnt + 1'b1;
                end
            end
        end
    end

    bar_decay_unit u_decay (
        .snap_mag   (snap[upd_idx]),
        .snap_valid (snap_valid),
        .cur_height (height[upd_idx]),
`ifdef PEAK_HOLD_EN
        .cur_peak   (peak[upd_idx]),
        .cur_hold   (hold[upd_idx]),
        .new_peak   (dec_peak),
        .new_hold   (dec_hold),
`endif
        .new_height (dec_height)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_BARS; i++)
                height[i] <= '0;
        end else if (upd_en) begin
            height[upd_idx] <= dec_height;
        end
    end

`ifdef PEAK_HOLD_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_BARS; i++) begin
                peak[i] <= '0;
                hold[i] <= '0;
            end
        end else if (upd_en) begin
            peak[upd_idx] <= dec_peak;
            hold[upd_idx] <= dec_hold;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < N_BARS; i++)
            peak[i] = '0;
    end
`endif
endmodule

// File: tb/tb_bar_height_scheduler.sv
// Directed bench for bar_height_scheduler with a frame-level reference model checked every cycle.
module tb_bar_height_scheduler;
    import bar_pkg::*;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         FRAME_TICK = 1'b0;
    bar_heights_t height;
    bar_heights_t peak;
    logic         control_bit;

    bar_height_scheduler_if bus();

    bar_height_scheduler dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .mag_bus     (bus),
        .FRAME_TICK  (FRAME_TICK),
        .height      (height),
        .control_bit (control_bit),
        .peak        (peak)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Frame-level model: a whole update is computed at once; m_phase is the cycle offset in the busy window.
    int m_acc [N_BARS];
    int m_snap [N_BARS];
    int m_h [N_BARS];
    int m_h_new [N_BARS];
    int m_pk [N_BARS];
    int m_pk_new [N_BARS];
    int m_hold [N_BARS];
    int m_hold_new [N_BARS];
    bit m_snap_valid;
    int m_bin;
    int m_phase = -1;
    bit m_pend;
    bit m_ready;
    bit m_accept;
    int m_bar;
    int m_t;
    localparam int BUSY_LEN = N_BARS + SETTLE_LEN + PULSE_LEN;

    function automatic void model_reset();
        for (int b = 0; b < N_BARS; b++) begin
            m_acc[b] = 0; m_snap[b] = 0; m_h[b] = 0; m_pk[b] = 0; m_hold[b] = 0;
        end
        m_snap_valid = 0; m_bin = 0; m_phase = -1; m_pend = 0;
    endfunction

    function automatic void compute_frame();
        for (int b = 0; b < N_BARS; b++) begin
            m_t = m_snap_valid ? ((m_snap[b] >> SHIFT) > MAX_HEIGHT ? MAX_HEIGHT : (m_snap[b] >> SHIFT)) : 0;
            m_h_new[b] = (m_t >= m_h[b]) ? m_t : ((m_h[b] > DECAY) ? m_h[b] - DECAY : 0);
            if (m_h_new[b] >= m_pk[b]) begin
                m_pk_new[b] = m_h_new[b]; m_hold_new[b] = PEAK_HOLD - 1;
            end else if (m_hold[b] > 0) begin
                m_pk_new[b] = m_pk[b]; m_hold_new[b] = m_hold[b] - 1;
            end else begin
                m_pk_new[b] = (m_pk[b] - 1 > m_h_new[b]) ? m_pk[b] - 1 : m_h_new[b];
                m_hold_new[b] = 0;
            end
        end
    endfunction

    always @(negedge CLK) begin
        if (!RESET_N) begin
            model_reset();
        end else begin
            m_ready = !(m_phase >= 0 && m_phase < N_BARS);
            check("mag_ready", int'(bus.MAG_READY), int'(m_ready));
            check("control_bit", int'(control_bit), (m_phase >= N_BARS + SETTLE_LEN) ? 1 : 0);
            if (m_ready) begin
                for (int b = 0; b < N_BARS; b++) begin
                    check($sformatf("height[%0d]", b), int'(height[b]), m_h[b]);
`ifdef PEAK_HOLD_EN
                    check($sformatf("peak[%0d]", b), int'(peak[b]), m_pk[b]);
`else
                    check($sformatf("peak[%0d]", b), int'(peak[b]), 0);
`endif
                end
            end
            m_accept = bus.MAG_VALID && m_ready;
            if (m_accept) begin
                m_bar = m_bin / BINS_PER_BAR;
                if (m_bar < N_BARS && int'(bus.MAG) > m_acc[m_bar]) m_acc[m_bar] = int'(bus.MAG);
                if (bus.MAG_LAST) begin
                    m_snap = m_acc;
                    for (int b = 0; b < N_BARS; b++) m_acc[b] = 0;
                    m_snap_valid = 1; m_bin = 0;
                end else begin
                    m_bin++;
                end
            end
            if (m_phase < 0) begin
                if (FRAME_TICK || m_pend) begin
                    m_pend = 0; m_phase = 0; compute_frame();
                end
            end else begin
                if (FRAME_TICK) m_pend = 1;
                m_phase++;
                if (m_phase == N_BARS) begin
                    m_h = m_h_new; m_pk = m_pk_new; m_hold = m_hold_new;
                end
                if (m_phase == BUSY_LEN) m_phase = -1;
            end
        end
    end

    // Timing measurements of the DUT's own outputs, compared to literal expectations below.
    int cyc = 0, upd_count = 0, rdy_fall_cyc = 0, rdy_run = 0, last_rdy_run = 0;
    int ctl_rise_cyc = 0, last_ctl_width = 0, last_rise_delay = 0;
    bit prev_rdy = 1'b1, prev_ctl = 1'b0;

    always @(negedge CLK) begin
        cyc++;
        if (RESET_N) begin
            if (prev_rdy && !bus.MAG_READY) begin upd_count++; rdy_fall_cyc = cyc; end
            if (!bus.MAG_READY) rdy_run++;
            else if (!prev_rdy) begin last_rdy_run = rdy_run; rdy_run = 0; end
            if (control_bit && !prev_ctl) begin ctl_rise_cyc = cyc; last_rise_delay = cyc - rdy_fall_cyc; end
            if (!control_bit && prev_ctl) last_ctl_width = cyc - ctl_rise_cyc;
        end
        prev_rdy = bus.MAG_READY;
        prev_ctl = control_bit;
    end

    function automatic logic [15:0] bin_val(input int kind, input int i);
        case (kind)
            0:       return 16'h1000;
            1:       return (i == 12) ? 16'hFFFF : 16'h0000;
            3:       return 16'(i * 512);
            4:       return 16'h2000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic beat(input logic [15:0] m, input bit last, input bit tk);
        int guard = 0;
        bit took = 1'b0;
        bus.MAG_VALID = 1'b1; bus.MAG = m; bus.MAG_LAST = last;
        if (tk) FRAME_TICK = 1'b1;
        while (!took) begin
            @(negedge CLK);
            took = bus.MAG_READY;
            @(posedge CLK); #1;
            if (tk) FRAME_TICK = 1'b0;
            guard++;
            if (guard > 100) begin check("beat_timeout", 0, 1); took = 1'b1; end
        end
        bus.MAG_VALID = 1'b0; bus.MAG_LAST = 1'b0;
    endtask

    task automatic spectrum(input int nbins, input int kind, input bit tick_on_last);
        for (int i = 0; i < nbins; i++)
            beat(bin_val(kind, i), i == nbins - 1, tick_on_last && (i == nbins - 1));
    endtask

    task automatic tick();
        FRAME_TICK = 1'b1;
        @(posedge CLK); #1;
        FRAME_TICK = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_ctl_high();
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge CLK);
            seen = control_bit;
        end
        if (!seen) check("ctl_high_timeout", 0, 1);
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    int upd0;

    initial begin
        bus.MAG_VALID = 1'b0; bus.MAG = '0; bus.MAG_LAST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(negedge CLK);
        check("reset ready", int'(bus.MAG_READY), 1);
        check("reset control_bit", int'(control_bit), 0);
        check("reset height[0]", int'(height[0]), 0);
        check("reset height[19]", int'(height[19]), 0);
        @(posedge CLK); #1;

        // Flat spectrum: 0x1000 >> 9 = 8 on every bar.
        spectrum(80, 0, 1'b0);
        tick();
        idle_wait(40);
        check("flat height[0]", int'(height[0]), 8);
        check("flat height[19]", int'(height[19]), 8);
        check("strobe delay", last_rise_delay, 24);
        check("strobe width", last_ctl_width, 8);
        check("ready low run", last_rdy_run, 20);

        // Saturating bin in bar 3, then an empty spectrum decays it by one.
        do_reset();
        spectrum(80, 1, 1'b0);
        tick();
        idle_wait(40);
        check("clamp height[3]", int'(height[3]), 48);
        check("clamp height[2]", int'(height[2]), 0);
        check("clamp height[4]", int'(height[4]), 0);
        spectrum(80, 2, 1'b0);
        tick();
        idle_wait(40);
        check("decay height[3]", int'(height[3]), 47);
        check("decay height[0]", int'(height[0]), 0);

        // Two ticks while busy collapse into one extra update.
        upd0 = upd_count;
        tick();
        wait_ctl_high();
        tick();
        idle_wait(2);
        tick();
        idle_wait(80);
        check("pending updates", upd_count - upd0, 2);
        check("pending height[3]", int'(height[3]), 45);

        // Stream stalls across an update; then the new spectrum lands on the next tick.
        fork
            spectrum(80, 3, 1'b0);
            begin idle_wait(10); tick(); end
        join
        tick();
        idle_wait(40);
        check("stall ready run", last_rdy_run, 20);
        check("ramp height[0]", int'(height[0]), 3);
        check("ramp height[3]", int'(height[3]), 43);
        check("ramp height[19]", int'(height[19]), 48);

        // Short spectrum whose last bin coincides with FRAME_TICK.
        do_reset();
        spectrum(40, 4, 1'b1);
        idle_wait(40);
        check("short height[0]", int'(height[0]), 16);
        check("short height[9]", int'(height[9]), 16);
        check("short height[10]", int'(height[10]), 0);
        check("short height[19]", int'(height[19]), 0);

        // Asynchronous reset in the middle of the strobe.
        tick();
        wait_ctl_high();
        check("pulse before reset", int'(control_bit), 1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async reset control_bit", int'(control_bit), 0);
        check("async reset height[0]", int'(height[0]), 0);
        check("async reset ready", int'(bus.MAG_READY), 1);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        idle_wait(2);

`ifdef PEAK_HOLD_EN
        spectrum(80, 1, 1'b0);
        tick();
        idle_wait(40);
        spectrum(80, 2, 1'b0);
        for (int f = 1; f <= 16; f++) begin
            tick();
            idle_wait(40);
            if (f == 15) check("peak hold [3]", int'(peak[3]), 48);
        end
        check("peak release [3]", int'(peak[3]), 47);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
